fun_sched: RTL and testbench

//  Round-robin scheduler sharing one fun unit (result = a * cbrt(b), 8b a/b, 11b result,

---
 rtl/fun_sched_pkg.sv | 16 +
 rtl/fun_sched_rr_arbiter.sv | 31 +++
 rtl/fun_sched.sv | 183 ++++++++++++++++++
 tb/tb_fun_sched.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fun_sched_pkg.sv
// Shared widths, FSM state encoding and default watchdog limit for the fun scheduler.
package fun_sched_pkg;

    localparam int unsigned A_W = 8;
    localparam int unsigned R_W = 11;
    localparam int unsigned TIMEOUT_CYC_DEF = 2000;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StArm,
        StRun,
        StDone
    } state_e;

endpackage

// File: rtl/fun_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request searching upward from ptr_i+1 (mod N).
module fun_sched_rr_arbiter #(
    parameter int unsigned N    = 4,
    parameter int unsigned IdxW = $clog2(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic            valid_o,
    output logic [N-1:0]    gnt_o,
    output logic [IdxW-1:0] idx_o
);

    logic [IdxW-1:0] cand;

    always_comb begin
        valid_o = 1'b0;
        gnt_o   = '0;
        idx_o   = '0;
        cand    = '0;
        // The pointer itself is visited last, so the just-served requester has lowest priority.
        for (int unsigned i = 1; i <= N; i++) begin
            cand = IdxW'((32'(ptr_i) + i) % N);
            if (!valid_o && req_i[cand]) begin
                valid_o     = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/fun_sched.sv
// Round-robin scheduler sharing one fun unit (a * cbrt(b)) among N requesters.
// Optional watchdog on the RUN wait is enabled by defining FUN_SCHED_TIMEOUT_EN.
module fun_sched
    import fun_sched_pkg::*;
#(
    parameter int unsigned N           = 4,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req_i,
    input  logic [A_W*N-1:0] a_i,
    input  logic [A_W*N-1:0] b_i,
    output logic [N-1:0]   gnt_o,
    output logic [N-1:0]   done_o,
    output logic [R_W-1:0] result_o,
    output logic           err_o,
    output logic           busy_o,
    output logic           fun_start,
    output logic [A_W-1:0] fun_a,
    output logic [A_W-1:0] fun_b,
    input  logic           fun_busy,
    input  logic [R_W-1:0] fun_result
);

    localparam int unsigned IdxW = $clog2(N);

    state_e          state_q, state_d;
    logic [IdxW-1:0] ptr_q, ptr_d;
    logic [IdxW-1:0] own_q, own_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [N-1:0]    done_q, done_d;
    logic            start_q, start_d;
    logic [R_W-1:0]  res_q, res_d;
    logic [A_W-1:0]  a_q, a_d;
    logic [A_W-1:0]  b_q, b_d;

    logic            arb_valid;
    logic [N-1:0]    arb_gnt;
    logic [IdxW-1:0] arb_idx;
    logic [A_W-1:0]  a_sel, b_sel;
    logic            run_expired;
    logic            tmo_q;

    fun_sched_rr_arbiter #(
        .N    (N),
        .IdxW (IdxW)
    ) u_rr_arbiter (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .valid_o (arb_valid),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx)
    );

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (arb_gnt[k]) begin
                a_sel = a_i[k*A_W +: A_W];
                b_sel = b_i[k*A_W +: A_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        own_d   = own_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        gnt_d   = '0;
        done_d  = '0;
        start_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (arb_valid) begin
                    gnt_d   = arb_gnt;
                    a_d     = a_sel;
                    b_d     = b_sel;
                    own_d   = arb_idx;
                    ptr_d   = arb_idx;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                start_d = 1'b1;
                state_d = StArm;
            end
            // Guard cycle: fun has not yet had a chance to raise busy.
            StArm: state_d = StRun;
            StRun: begin
                if (!fun_busy || run_expired) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                res_d         = tmo_q ? '0 : fun_result;
                done_d[own_q] = 1'b1;
                state_d       = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            ptr_q   <= IdxW'(N - 1);
            own_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            start_q <= 1'b0;
            res_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            own_q   <= own_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            start_q <= start_d;
            res_q   <= res_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

`ifdef FUN_SCHED_TIMEOUT_EN
    logic [31:0] cnt_q, cnt_d;
    logic        tmo_d;
    logic        err_q, err_d;

    assign run_expired = (cnt_q >= TIMEOUT_CYC);

    always_comb begin
        cnt_d = cnt_q;
        tmo_d = tmo_q;
        err_d = (state_q == StDone) && tmo_q;
        if (state_q == StIssue) begin
            cnt_d = '0;
            tmo_d = 1'b0;
        end else if (state_q == StArm) begin
            cnt_d = cnt_q + 32'd1;
        end else if (state_q == StRun) begin
            cnt_d = cnt_q + 32'd1;
            if (fun_busy && run_expired) begin
                tmo_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign run_expired = 1'b0;
    assign tmo_q       = 1'b0;
    assign err_o       = 1'b0;
`endif

    assign gnt_o     = gnt_q;
    assign done_o    = done_q;
    assign result_o  = res_q;
    assign busy_o    = (state_q != StIdle);
    assign fun_start = start_q;
    assign fun_a     = a_q;
    assign fun_b     = b_q;

endmodule

// File: tb/tb_fun_sched.sv
// Self-checking bench for fun_sched: behavioural fun model, scoreboard monitor, vector table.
module tb_fun_sched;

    localparam int unsigned N   = 4;
    localparam int unsigned TMO = 16;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req_i;
    logic [8*N-1:0] a_i;
    logic [8*N-1:0] b_i;
    logic [N-1:0]   gnt_o;
    logic [N-1:0]   done_o;
    logic [10:0]    result_o;
    logic           err_o;
    logic           busy_o;
    logic           fun_start;
    logic [7:0]     fun_a;
    logic [7:0]     fun_b;
    logic           fun_busy;
    logic [10:0]    fun_result;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int busy_lat = 0;
    bit hang = 1'b0;
    bit expect_err = 1'b0;
    int fb_cnt;
    int done_res [N];
    bit gnt_prev = 1'b0;

    typedef struct {
        int idx;
        int res;
        int cyc;
        int lat;
        bit err;
    } sb_t;
    sb_t sb_q[$];
    int  grant_log[$];

    typedef struct {
        int k;
        int a;
        int b;
        int lat;
        int res;
    } vec_t;
    vec_t vt [8];

    fun_sched #(
        .N           (N),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req_i),
        .a_i        (a_i),
        .b_i        (b_i),
        .gnt_o      (gnt_o),
        .done_o     (done_o),
        .result_o   (result_o),
        .err_o      (err_o),
        .busy_o     (busy_o),
        .fun_start  (fun_start),
        .fun_a      (fun_a),
        .fun_b      (fun_b),
        .fun_busy   (fun_busy),
        .fun_result (fun_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int cbrt(input int v);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    function automatic int op_of(input logic [8*N-1:0] vec, input int k);
        logic [8*N-1:0] t;
        t = vec >> (8 * k);
        return int'(t[7:0]);
    endfunction

    function automatic int onehot_idx(input logic [N-1:0] v);
        for (int i = 0; i < int'(N); i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Fun unit model: result ready with busy; busy held busy_lat cycles (or forever while hang).
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            fun_busy   <= 1'b0;
            fb_cnt     <= 0;
            fun_result <= '0;
        end else if (fun_start) begin
            fun_result <= 11'(int'(fun_a) * cbrt(int'(fun_b)));
            fb_cnt     <= busy_lat;
            fun_busy   <= (busy_lat != 0) || hang;
        end else if (hang) begin
            fun_busy <= 1'b1;
        end else if (fb_cnt > 1) begin
            fb_cnt <= fb_cnt - 1;
        end else begin
            fb_cnt   <= 0;
            fun_busy <= 1'b0;
        end
    end

    always @(negedge clk) begin
        sb_t e;
        int  k;
        if (!rst) begin
            gnt_prev = 1'b0;
        end else begin
            if (gnt_prev || fun_start) check("start_follows_gnt", int'(fun_start), int'(gnt_prev));
            if (|gnt_o) begin
                k = onehot_idx(gnt_o);
                check("gnt_onehot", int'($onehot(gnt_o)), 1);
                check("single_in_flight", sb_q.size(), 0);
                e.idx = k;
                e.err = expect_err;
                e.res = expect_err ? 0 : op_of(a_i, k) * cbrt(op_of(b_i, k));
                e.cyc = cyc;
                e.lat = busy_lat;
                sb_q.push_back(e);
                grant_log.push_back(k);
            end
            if (|done_o) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", int'(done_o), 0);
                end else begin
                    e = sb_q.pop_front();
                    check("done_onehot", int'($onehot(done_o)), 1);
                    check("done_owner", onehot_idx(done_o), e.idx);
                    check("done_result", int'(result_o), e.res);
                    check("done_err", int'(err_o), int'(e.err));
                    if (!e.err) check("latency", cyc - e.cyc, 4 + e.lat);
                    done_res[e.idx] = int'(result_o);
                end
            end else if (err_o) begin
                check("err_outside_done", int'(err_o), 0);
            end
            gnt_prev = |gnt_o;
        end
    end

    task automatic raise(input int k, input int a, input int b);
        req_i[k]       = 1'b1;
        a_i[8*k +: 8]  = 8'(a);
        b_i[8*k +: 8]  = 8'(b);
    endtask

    task automatic wait_gnt(input int k, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (gnt_o[k]) ok = 1'b1;
        end
        check("gnt_arrived", int'(ok), 1);
    endtask

    task automatic wait_done(input int k, input int bound, output int res);
        bit seen;
        seen = 1'b0;
        res  = -1;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (done_o[k]) begin
                seen = 1'b1;
                res  = int'(result_o);
            end
        end
        check("done_arrived", int'(seen), 1);
    endtask

    task automatic run_job(input int k, input int a, input int b, input int lat, output int res);
        bit ok;
        busy_lat = lat;
        res = -1;
        @(posedge clk);
        #1;
        raise(k, a, b);
        wait_gnt(k, ok);
        req_i[k] = 1'b0;
        if (ok) wait_done(k, 40 + lat, res);
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_gnt"}, int'(gnt_o), 0);
        check({tag, "_done"}, int'(done_o), 0);
        check({tag, "_start"}, int'(fun_start), 0);
        check({tag, "_err"}, int'(err_o), 0);
        check({tag, "_busy"}, int'(busy_o), 0);
        check({tag, "_result"}, int'(result_o), 0);
        check({tag, "_fun_a"}, int'(fun_a), 0);
        check({tag, "_fun_b"}, int'(fun_b), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int  res;
        bit  ok;
        vt[0] = '{0, 5, 27, 3, 15};
        vt[1] = '{1, 3, 64, 2, 12};
        vt[2] = '{2, 9, 125, 0, 45};
        vt[3] = '{3, 255, 255, 1, 1530};
        vt[4] = '{0, 2, 200, 4, 10};
        vt[5] = '{1, 7, 1, 5, 7};
        vt[6] = '{2, 10, 8, 0, 20};
        vt[7] = '{3, 1, 0, 2, 0};

        rst   = 1'b0;
        req_i = '0;
        a_i   = '0;
        b_i   = '0;
        repeat (3) @(negedge clk);
        check_quiet("reset");
        rst = 1'b1;

        // Single requests, distinct operands and busy lengths; last entry leaves pointer at 3.
        foreach (vt[i]) begin
            run_job(vt[i].k, vt[i].a, vt[i].b, vt[i].lat, res);
            check("table_result", res, vt[i].res);
        end

        // Contention: 0 and 2 together, 0 wins first.
        busy_lat = 2;
        grant_log.delete();
        @(posedge clk);
        #1;
        raise(0, 3, 64);
        raise(2, 9, 125);
        wait_gnt(0, ok);
        req_i[0] = 1'b0;
        wait_gnt(2, ok);
        req_i[2] = 1'b0;
        wait_done(2, 60, res);
        check("contention_res2", res, 45);
        check("contention_res0", done_res[0], 12);
        check("contention_grants", grant_log.size(), 2);
        if (grant_log.size() >= 2) begin
            check("contention_first", grant_log[0], 0);
            check("contention_second", grant_log[1], 2);
        end
        @(posedge clk);
        #1;

        // Fairness: everyone requesting; pointer is 2, so rotation starts at 3.
        busy_lat = 1;
        grant_log.delete();
        for (int k = 0; k < int'(N); k++) raise(k, k + 1, (k + 2) * (k + 2) * (k + 2));
        for (int i = 0; i < 300 && grant_log.size() < 8; i++) @(negedge clk);
        req_i = '0;
        for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(negedge clk);
        check("fair_count", grant_log.size(), 8);
        if (grant_log.size() >= 8) begin
            for (int i = 0; i < 8; i++) check("fair_order", grant_log[i], (3 + i) % 4);
        end
        @(posedge clk);
        #1;

        // Operand stability: inputs change right after grant.
        busy_lat = 6;
        raise(1, 4, 27);
        wait_gnt(1, ok);
        #1;
        req_i[1]    = 1'b0;
        a_i[15:8]   = 8'd200;
        b_i[15:8]   = 8'd200;
        res = -1;
        for (int i = 0; i < 30 && res < 0; i++) begin
            @(negedge clk);
            if (busy_o) begin
                check("stable_fun_a", int'(fun_a), 4);
                check("stable_fun_b", int'(fun_b), 27);
            end
            if (done_o[1]) res = int'(result_o);
        end
        check("stable_result", res, 12);
        @(posedge clk);
        #1;

        // Reset while fun is busy.
        busy_lat = 20;
        raise(3, 6, 64);
        wait_gnt(3, ok);
        req_i[3] = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (fun_busy && busy_o) ok = 1'b1;
        end
        check("reached_run", int'(ok), 1);
        #2;
        rst = 1'b0;
        #1;
        check_quiet("midreset");
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        run_job(1, 5, 27, 2, res);
        check("post_reset_result", res, 15);

`ifdef FUN_SCHED_TIMEOUT_EN
        hang = 1'b1;
        expect_err = 1'b1;
        run_job(0, 5, 27, 0, res);
        check("timeout_result", res, 0);
        hang = 1'b0;
        expect_err = 1'b0;
        repeat (2) @(negedge clk);
        run_job(2, 9, 125, 1, res);
        check("after_timeout_result", res, 45);
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
